xif_issue_queue: RTL
====================

XIF_ISSUE_QUEUE -- requirements
Module: xif_issue_queue

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- XLEN, 32, operand width
- X_NUM_RS, 2, source operands per request
- X_ID_WIDTH, 4, instruction id width
- DEPTH, 4, queue entries (power of 2, >=2)
- OPCODE, 7'b0001011, accepted major opcode (custom-0)
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- issue_valid_i  in  1  CPU issue request valid
- issue_ready_o  out  1  issue handshake completes this cycle
- issue_instr_i  in  32  offloaded instruction
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs_i  in  X_NUM_RS*XLEN  source operands, rs[0] in LSBs
- issue_rs_valid_i  in  X_NUM_RS  operand valid flags
- issue_accept_o  out  1  response: instruction accepted
- issue_writeback_o  out  1  response: accepted and rd!=0
- commit_valid_i  in  1  commit transaction valid
- commit_id_i  in  X_ID_WIDTH  id being committed or killed
- commit_kill_i  in  1  1=kill, 0=commit
- exec_valid_o  out  1  head entry offered to execution unit
- exec_ready_i  in  1  execution unit takes head
- exec_instr_o  out  32  head instruction
- exec_id_o  out  X_ID_WIDTH  head id
- exec_rs_o  out  X_NUM_RS*XLEN  head operands
- count_o  out  $clog2(DEPTH)+1  occupied entries

Function
REQ-003 Match SHALL be defined as issue_instr_i[6:0]==OPCODE.
REQ-004 issue_ready_o SHALL be combinational: issue_valid_i & (all issue_rs_valid_i set) & (!match | !full).
REQ-005 issue_accept_o SHALL equal issue_ready_o & match; issue_writeback_o SHALL equal issue_accept_o & (issue_instr_i[11:7]!=0); both 0 when issue_ready_o=0.
REQ-006 A non-matching request SHALL be rejected in the handshake cycle, even when full, and SHALL NOT be enqueued.
REQ-007 An accepted handshake SHALL write {instr, id, rs} at the tail at the next clock edge, with state PENDING.
REQ-008 Each entry SHALL have state EMPTY, PENDING, COMMITTED or KILLED; transitions: EMPTY->PENDING on push; PENDING->COMMITTED on commit_valid_i & !commit_kill_i & id match; PENDING->KILLED on commit_valid_i & commit_kill_i & id match; COMMITTED/KILLED->EMPTY on leaving the head.
REQ-009 A commit for an id absent from the queue SHALL be ignored; a commit for an id whose push shares the same cycle SHALL apply to the new entry.
REQ-010 Commit SHALL affect only the oldest PENDING entry with a matching id.
REQ-011 exec_valid_o SHALL be 1 iff the head is COMMITTED; exec_* outputs SHALL come directly from head registers (no combinational path from issue_* inputs).
REQ-012 The head SHALL pop on exec_valid_o & exec_ready_i; a KILLED head SHALL pop one cycle after reaching the head, with exec_valid_o=0.
REQ-013 exec_valid_o SHALL NOT drop and exec_* SHALL NOT change while exec_ready_i=0.
REQ-014 Minimum latency SHALL be: push at edge N, commit in cycle N, exec_valid_o=1 in cycle N+1.
REQ-015 Pointers SHALL wrap modulo DEPTH; count_o SHALL be unchanged on a simultaneous push and pop, including when full (a pop frees space only on the next cycle for REQ-004).
REQ-016 Full SHALL mean count_o==DEPTH; while full, a matching request SHALL see issue_ready_o=0.

Reset
REQ-017 While rst_i=1 at a clock edge, all entries SHALL be EMPTY, pointers 0, count_o=0; exec_valid_o=0, exec_* data 0; issue_ready_o/accept/writeback follow REQ-004/005 with queue empty.
REQ-018 Reset mid-operation SHALL discard all entries, including COMMITTED entries, with no exec handshake.

Verification
REQ-019 Issue instr=0x0000108B, id=3, rs valid; commit id=3 -> accept=1, writeback=1, exec_valid_o next cycle, exec_id_o=3.
REQ-020 Issue instr=0x00000033 (OP) -> ready=1, accept=0, writeback=0; count_o stays 0.
REQ-021 Push ids 0..3 (DEPTH=4), then issue matching id=4 -> issue_ready_o=0 until a pop, count_o=4.
REQ-022 Push ids 1,2; kill id 1, commit id 2 -> id 1 dropped without exec_valid_o, then exec_id_o=2.
REQ-023 Issue with rs_valid=2'b01 for 3 cycles, then 2'b11 -> ready only in cycle 4.
REQ-024 Two committed entries, exec_ready_i=0 for 5 cycles, then rst_i=1 -> exec data stable for 5 cycles, then count_o=0, exec_valid_o=0.

Source files
------------

// File: rtl/xif_issue_queue.sv
// xif_issue_queue
// In-order issue queue for coprocessor-offloaded instructions.
// Requests whose major opcode matches OPCODE are accepted and buffered.
// Each entry then waits for the CPU to commit or kill it. A committed entry
// at the head is offered to the execution unit. A killed entry at the head
// is dropped silently.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   issue_*                  CPU issue handshake: request, operands, response
//   commit_*                 commit/kill transaction addressed by instruction id
//   exec_*                   head entry offered to the execution unit
//   count_o                  number of occupied entries
module xif_issue_queue #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned X_NUM_RS   = 2,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter logic [6:0]  OPCODE     = 7'b0001011
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [31:0]                  issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]        issue_id_i,
  input  logic [X_NUM_RS*XLEN-1:0]     issue_rs_i,
  input  logic [X_NUM_RS-1:0]          issue_rs_valid_i,
  output logic                         issue_accept_o,
  output logic                         issue_writeback_o,
  input  logic                         commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]        commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         exec_valid_o,
  input  logic                         exec_ready_i,
  output logic [31:0]                  exec_instr_o,
  output logic [X_ID_WIDTH-1:0]        exec_id_o,
  output logic [X_NUM_RS*XLEN-1:0]     exec_rs_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RS_W  = X_NUM_RS * XLEN;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_PENDING   = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } entry_state_t;

  entry_state_t                state_q [DEPTH];
  entry_state_t                state_d [DEPTH];
  logic [31:0]                 instr_q [DEPTH];
  logic [X_ID_WIDTH-1:0]       id_q    [DEPTH];
  logic [RS_W-1:0]             rs_q    [DEPTH];

  logic [PTR_W-1:0]            head_q, head_d;
  logic [PTR_W-1:0]            tail_q, tail_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic                        match_s;
  logic                        full_s;
  logic                        push_s;
  logic                        pop_s;
  entry_state_t                head_state_s;
  logic [DEPTH-1:0]            pend_hit_s;   // indexed by age offset from head
  logic                        hit_s;
  logic [PTR_W-1:0]            hit_idx_s;
  entry_state_t                commit_state_s;
  entry_state_t                new_state_s;

  // Issue handshake: non-matching requests are answered even when full.
  always_comb begin
    match_s           = (issue_instr_i[6:0] == OPCODE);
    full_s            = (count_q == DEPTH_C);
    issue_ready_o     = issue_valid_i & (&issue_rs_valid_i) & (~match_s | ~full_s);
    issue_accept_o    = issue_ready_o & match_s;
    issue_writeback_o = issue_accept_o & (issue_instr_i[11:7] != 5'd0);
    push_s            = issue_accept_o;
  end

  // Head pop: committed entries leave on the exec handshake, killed ones unconditionally.
  always_comb begin
    head_state_s = state_q[head_q];
    pop_s        = ((head_state_s == ST_COMMITTED) & exec_ready_i) |
                   (head_state_s == ST_KILLED);
  end

  // Oldest pending entry whose id matches the commit; scanned in age order from head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pend_hit_s[i] = (CNT_W'(i) < count_q) &&
                      (state_q[head_q + PTR_W'(i)] == ST_PENDING) &&
                      (id_q[head_q + PTR_W'(i)] == commit_id_i);
    end
    hit_s     = commit_valid_i & (|pend_hit_s);
    hit_idx_s = head_q;
    // Descending scan so the youngest-offset (oldest) hit is written last.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_idx_s = pend_hit_s[i] ? (head_q + PTR_W'(i)) : hit_idx_s;
    end
    commit_state_s = commit_kill_i ? ST_KILLED : ST_COMMITTED;
    // A commit that finds no queued match applies to the entry pushed this cycle.
    new_state_s    = (commit_valid_i && !hit_s && (commit_id_i == issue_id_i)) ?
                     commit_state_s : ST_PENDING;
  end

  // Per-entry next state; pop, commit and push never target the same slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (pop_s && (head_q == PTR_W'(i))) begin
        state_d[i] = ST_EMPTY;
      end else if (hit_s && (hit_idx_s == PTR_W'(i))) begin
        state_d[i] = commit_state_s;
      end else if (push_s && (tail_q == PTR_W'(i))) begin
        state_d[i] = new_state_s;
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at power-of-2 depth.
  always_comb begin
    head_d  = pop_s  ? (head_q + PTR_W'(1)) : head_q;
    tail_d  = push_s ? (tail_q + PTR_W'(1)) : tail_q;
    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
  end

  // Queue storage and pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_EMPTY;
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        rs_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
      end
      if (push_s) begin
        instr_q[tail_q] <= issue_instr_i;
        id_q[tail_q]    <= issue_id_i;
        rs_q[tail_q]    <= issue_rs_i;
      end
    end
  end

  // Exec side is driven only from head registers.
  always_comb begin
    exec_valid_o = (state_q[head_q] == ST_COMMITTED);
    exec_instr_o = instr_q[head_q];
    exec_id_o    = id_q[head_q];
    exec_rs_o    = rs_q[head_q];
    count_o      = count_q;
  end

endmodule
